// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StError
    } loader_state_e;

    localparam int unsigned LOADER_ADDR_WIDTH = 8;
    localparam int unsigned LOADER_MAX_WORDS  = 32'd1 << LOADER_ADDR_WIDTH;

    // Capacity in words for a given word-address width.
    function automatic int unsigned loader_max_words(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes MSB-first into one 32-bit word; word_done_o marks the
// cycle whose accepted byte completes the word.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word_done_o = byte_en_i && (cnt_q == 2'd3);
    assign word_o      = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes big-endian words into instruction memory,
// verifies an XOR checksum and only then releases the core via cpu_run.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  error
);

    localparam int unsigned MaxWords = loader_max_words(ADDR_WIDTH);

    loader_state_e         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [7:0]            xor_q, xor_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        xfer;
    logic        asm_en;
    logic        asm_clr;
    logic        word_done;
    logic [31:0] word;
    logic [15:0] len_rx;
    logic        last_word;

    assign byte_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StData)  || (state_q == StCheck);
    assign xfer       = byte_valid && byte_ready;
    assign asm_en     = xfer && (state_q == StData);
    assign asm_clr    = (state_q == StIdle);
    assign len_rx     = {len_q[15:8], byte_data};
    assign last_word  = (word_cnt_q == 16'(len_q - 16'd1));

    word_assembler u_word_assembler (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clr_i       (asm_clr),
        .byte_en_i   (asm_en),
        .byte_i      (byte_data),
        .word_done_o (word_done),
        .word_o      (word)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                // Everything frame-scoped is cleared on the way into LEN_HI.
                len_d      = '0;
                word_cnt_d = '0;
                xor_d      = '0;
                state_d    = StLenHi;
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_rx == 16'd0) begin
                        state_d = StCheck;
                    end else if (32'(len_rx) > MaxWords) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    xor_d = xor_q ^ byte_data;
                    if (word_done) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = word;
                        word_cnt_d = 16'(word_cnt_q + 16'd1);
                        if (last_word) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (xfer) begin
                    state_d = (byte_data == xor_q) ? StDone : StError;
                end
            end
            StDone, StError: begin
                if (start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_run    = (state_q == StDone);
    assign error      = (state_q == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Directed sequence of framed loads with random payloads, compared against a
// frame-parsing reference model and a log of observed memory writes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned AW = LOADER_ADDR_WIDTH;

    typedef logic [7:0] bq_t [$];

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          start = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          error;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];

    always #5 CLK = ~CLK;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .error      (error)
    );

    // Memory-side write log, sampled mid-cycle.
    always @(negedge CLK) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_we"},    64'(imem_we),    64'd0);
        chk({tag, "_addr"},  64'(imem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_run"},   64'(cpu_run),    64'd0);
        chk({tag, "_err"},   64'(error),      64'd0);
    endtask

    function automatic bq_t make_frame(input int n, input logic [7:0] corrupt);
        bq_t f;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
        end
        f.push_back(x ^ corrupt);
        return f;
    endfunction

    task automatic wait_ready(input string tag);
        int wc;
        wc = 0;
        while (!byte_ready && wc < 50) begin
            @(negedge CLK);
            wc++;
        end
        if (wc >= 50) chk({tag, "_ready_timeout"}, 64'(byte_ready), 64'd1);
    endtask

    // Pushes the first cnt bytes (all when cnt < 0); gap is the idle percentage.
    task automatic send_bytes(input bq_t f, input int cnt, input int gap, input int start_idx);
        int wc;
        int lim;
        lim = (cnt < 0) ? f.size() : cnt;
        for (int i = 0; i < lim; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge CLK);
            end
            if (i == start_idx) start = 1'b1;
            if (i == start_idx + 2) start = 1'b0;
            byte_valid = 1'b1;
            byte_data  = f[i];
            wc = 0;
            while (!byte_ready && wc < 100) begin
                @(negedge CLK);
                wc++;
            end
            stalls += wc;
            if (wc >= 100) begin
                chk("byte_accept_timeout", 64'(byte_ready), 64'd1);
                break;
            end
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    // Reference: parse the frame and derive the writes and final status it implies.
    task automatic check_frame(input bq_t f, input string tag);
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        bit ok;
        n = int'({f[0], f[1]});
        x = 8'h00;
        if (n > int'(LOADER_MAX_WORDS)) begin
            chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'd0);
            chk({tag, "_run"},     64'(cpu_run),     64'd0);
            chk({tag, "_err"},     64'(error),       64'd1);
        end else begin
            chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(n));
            for (int i = 0; i < n; i++) begin
                w = {f[2 + 4 * i], f[3 + 4 * i], f[4 + 4 * i], f[5 + 4 * i]};
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                if (i < wa_q.size()) begin
                    chk({tag, "_addr"},  64'(wa_q[i]), 64'(i));
                    chk({tag, "_wdata"}, 64'(wd_q[i]), 64'(w));
                end
            end
            ok = (f[2 + 4 * n] == x);
            chk({tag, "_run"}, 64'(cpu_run), 64'(ok));
            chk({tag, "_err"}, 64'(error),   64'(!ok));
        end
        chk({tag, "_ready_low"}, 64'(byte_ready), 64'd0);
    endtask

    task automatic run_frame(input bq_t f, input int gap, input int start_idx, input string tag);
        wa_q.delete();
        wd_q.delete();
        send_bytes(f, -1, gap, start_idx);
        @(negedge CLK);
        check_frame(f, tag);
    endtask

    task automatic restart(input string tag);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_ready(tag);
    endtask

    initial begin
        bq_t f;
        logic [31:0] w0;

        // Reset values, then IDLE for one cycle before byte_ready rises.
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_values("rst");
        RST = 1'b0;
        #1;
        chk("idle_after_rst_ready", 64'(byte_ready), 64'd0);
        @(negedge CLK);
        chk("lenhi_ready", 64'(byte_ready), 64'd1);

        // Single word with known checksum.
        f = '{8'h00, 8'h01, 8'h20, 8'h11, 8'h00, 8'h05, 8'h34};
        run_frame(f, 0, -1, "n1");
        if (wd_q.size() > 0) chk("n1_known_word", 64'(wd_q[0]), 64'h20110005);

        // Three words, one byte per cycle, no stall allowed.
        restart("n3");
        stalls = 0;
        f = make_frame(3, 8'h00);
        run_frame(f, 0, -1, "n3");
        chk("n3_stalls", 64'(stalls), 64'd0);

        // Bad checksum, then recovery with a good frame.
        restart("bad");
        run_frame(make_frame(2, 8'h01), 0, -1, "bad");
        restart("good");
        run_frame(make_frame(2, 8'h00), 0, -1, "good");

        // Empty frame and oversize length.
        restart("n0");
        f = '{8'h00, 8'h00, 8'h00};
        run_frame(f, 0, -1, "n0");
        restart("big");
        f = '{8'h01, 8'h01};
        run_frame(f, 0, -1, "big");

        // Reset mid-frame after six data bytes: only the complete first word exists.
        restart("midrst");
        wa_q.delete();
        wd_q.delete();
        f = make_frame(2, 8'h00);
        send_bytes(f, 8, 0, -1);
        RST = 1'b1;
        #1;
        chk_reset_values("midrst");
        repeat (2) @(negedge CLK);
        chk("midrst_nwrites", 64'(wa_q.size()), 64'd1);
        w0 = {f[2], f[3], f[4], f[5]};
        if (wd_q.size() > 0) chk("midrst_word0", 64'(wd_q[0]), 64'(w0));
        RST = 1'b0;
        wait_ready("postrst");
        run_frame(make_frame(2, 8'h00), 0, -1, "postrst");

        // Random valid gaps with a start pulse during DATA.
        restart("gappy");
        run_frame(make_frame(4, 8'h00), 40, 6, "gappy");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It receives a framed program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into consecutive instruction-memory word slots. It verifies an XOR checksum, then asserts `cpu_run` to release the core; until then, the core is held idle.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
- One clock; reset is asynchronous and active-high.
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `byte_valid` input 1: source has a byte on `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `start` input 1: re-arm pulse, honoured only in DONE or ERROR.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_WIDTH: word address, byte address = `imem_addr`<<2.
- `imem_wdata` output 32: word to write.
- `cpu_run` output 1: high only in DONE; gates the core's PC/register updates.
- `error` output 1: high only in ERROR.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then one checksum byte = XOR of all data bytes.
- A transfer occurs on a rising edge where `byte_valid && byte_ready`.
- States:
  - IDLE → LEN_HI unconditionally.
  - LEN_HI → LEN_LO on transfer.
  - LEN_LO → DATA on transfer if 0 < N ≤ 2^ADDR_WIDTH; → CHECK if N = 0; → ERROR if N > 2^ADDR_WIDTH.
  - DATA → CHECK on transfer of byte 4·N.
  - CHECK → DONE on transfer if byte equals running XOR; otherwise → ERROR.
  - DONE/ERROR → IDLE when `start`=1; otherwise hold.
- `byte_ready` = 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERROR.
- Running XOR and word counter clear on entry to LEN_HI. Byte-in-word counter: 2 bits, wraps 3→0.
- The 4th byte of each word produces a write. `imem_addr` = word index (0..N−1, mod 2^ADDR_WIDTH is never reached because N is bounded).
- Words already written before an ERROR remain in memory. `cpu_run` never asserts from ERROR.
- `start` in any other state is ignored. `byte_valid` with `byte_ready`=0 is not consumed.

## Timing
- Reset values (while `RST` high and after release): state IDLE, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `error`=0, counters and XOR = 0.
- First cycle after reset release: IDLE; `byte_ready` rises on the following cycle.
- Write latency: `imem_we` is high for exactly the one cycle after the edge accepting a word's 4th byte. `imem_addr`/`imem_wdata` are registered and stable in that cycle.
- Back-to-back bytes (one per cycle) are sustained with no stall. A write cycle overlaps acceptance of the next word's first byte.
- `cpu_run`/`error` rise one cycle after the deciding CHECK (or LEN_LO) transfer.
- Reset asserted mid-frame: immediately returns to the reset values; no partial word is written.

## Structure
- Shared package `imem_loader_pkg`: state enumeration (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR), `LOADER_MAX_WORDS` derived from ADDR_WIDTH.
- One natural sub-module, `word_assembler`: 4-byte big-endian shift register plus 2-bit byte counter, emitting `word_done` and the 32-bit word. The FSM, word counter and checksum stay in the top.

## Test plan
- Reset, then N=1 and bytes 20 11 00 05 with checksum 0x34 → one `imem_we` pulse, addr 0, wdata 0x20110005; `cpu_run`=1.
- N=3 streamed one byte per cycle with correct checksum → writes at addr 0,1,2 on consecutive-word boundaries; no `byte_ready` drop; DONE.
- N=2 with checksum off by 0x01 → both words written, `error`=1, `cpu_run`=0; then `start` → IDLE, and a valid frame loads → DONE.
- N=0, checksum 0x00 → DONE with no `imem_we`. N=0x0101 with ADDR_WIDTH=8 → ERROR after LEN_LO, no writes.
- `RST` pulse after 6 data bytes → all outputs at reset values, no write for the partial word; a fresh frame loads correctly.
- `byte_valid` toggling randomly during a 4-word frame → identical memory contents and DONE; `start` pulse during DATA is ignored.
